// File: rtl/sw_pkg.sv
// Shared definitions for the sw_debounce switch conditioner (optional
// press pulses are enabled by defining SW_DEBOUNCE_PRESS_PULSE_EN).
package sw_pkg;

    localparam int unsigned SW_CNT_MAX_DEF = 50000;
    localparam int unsigned SW_CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } db_state_e;

endpackage

// File: rtl/db_chan.sv
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM with a
// saturating stability counter, and a press pulse under SW_DEBOUNCE_PRESS_PULSE_EN.
module db_chan
    import sw_pkg::*;
#(
    parameter int unsigned CNT_MAX = SW_CNT_MAX_DEF,
    parameter int unsigned CNT_W   = SW_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
    ,
    output logic press
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             db_q, db_d;
    logic             sync_s;

    assign sync_s = sync_q[1];
    assign sync_d = {sync_q[0], sw_raw};

    // Entering CHK_x already accounts for the first stable sample, so the
    // count only has to climb to CNT_MAX-1 for CNT_MAX stable samples.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        unique case (state_q)
            REL: begin
                if (!sync_s) begin
                    state_d = CHK_P;
                    cnt_d   = '0;
                end
            end
            CHK_P: begin
                if (sync_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_inc >= CNT_LAST) begin
                    state_d = PRS;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRS: begin
                if (sync_s) begin
                    state_d = CHK_R;
                    cnt_d   = '0;
                end
            end
            CHK_R: begin
                if (!sync_s) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_inc >= CNT_LAST) begin
                    state_d = REL;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                db_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= REL;
            cnt_q   <= '0;
            db_q    <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign sw_db = db_q;

`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
    logic press_q, press_d;

    always_comb begin
        press_d = (state_q == CHK_P) && (state_d == PRS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= press_d;
        end
    end

    assign press = press_q;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Two-channel active-low switch debouncer; PRESS1/PRESS2 pulse ports exist
// only when SW_DEBOUNCE_PRESS_PULSE_EN is defined.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned CNT_MAX = SW_CNT_MAX_DEF,
    parameter int unsigned CNT_W   = SW_CNT_W_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SW1,
    input  logic SW2,
    output logic SW1_DB,
    output logic SW2_DB
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
    ,
    output logic PRESS1,
    output logic PRESS2
`endif
);

    db_chan #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) u_chan1 (
        .clk   (CLK),
        .rst_n (RST_N),
        .sw_raw(SW1),
        .sw_db (SW1_DB)
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
        ,
        .press (PRESS1)
`endif
    );

    db_chan #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) u_chan2 (
        .clk   (CLK),
        .rst_n (RST_N),
        .sw_raw(SW2),
        .sw_db (SW2_DB)
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
        ,
        .press (PRESS2)
`endif
    );

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with CNT_MAX=4: run-length reference model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_sw_debounce;

    localparam int unsigned CNT_MAX = 4;

    logic CLK = 1'b0;
    logic RST_N;
    logic SW1;
    logic SW2;
    logic SW1_DB;
    logic SW2_DB;
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
    logic PRESS1;
    logic PRESS2;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    sw_debounce #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .SW1   (SW1),
        .SW2   (SW2),
        .SW1_DB(SW1_DB),
        .SW2_DB(SW2_DB)
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
        ,
        .PRESS1(PRESS1),
        .PRESS2(PRESS2)
`endif
    );

    // Reference: raw input delayed two samples; the level flips once CNT_MAX
    // consecutive delayed samples disagree with it.
    typedef struct {
        logic        s_a;
        logic        s_b;
        logic        db;
        logic        pr;
        int unsigned run;
    } ch_t;

    ch_t m1, m2;

    function automatic ch_t ch_reset();
        ch_t r;
        r.s_a = 1'b1;
        r.s_b = 1'b1;
        r.db  = 1'b1;
        r.pr  = 1'b0;
        r.run = 0;
        return r;
    endfunction

    function automatic ch_t ch_next(ch_t c, logic raw);
        ch_t n;
        n     = c;
        n.s_a = raw;
        n.s_b = c.s_a;
        n.pr  = 1'b0;
        if (c.s_b != c.db) n.run = c.run + 1;
        else               n.run = 0;
        if (n.run == CNT_MAX) begin
            n.db  = ~c.db;
            n.pr  = ~n.db;
            n.run = 0;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m1 <= ch_reset();
            m2 <= ch_reset();
        end else begin
            m1 <= ch_next(m1, SW1);
            m2 <= ch_next(m2, SW2);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_sw1_db", SW1_DB, m1.db);
            check("model_sw2_db", SW2_DB, m2.db);
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
            check("model_press1", PRESS1, m1.pr);
            check("model_press2", PRESS2, m2.pr);
`endif
        end
    end

    // Inputs change 1 time unit after a rising edge; n rising edges elapse.
    task automatic step(input logic a, input logic b, input int unsigned n);
        repeat (n) begin
            SW1 = a;
            SW2 = b;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic lit(input string name, input logic d1, input logic d2);
        check({name, "_sw1_db"}, SW1_DB, d1);
        check({name, "_sw2_db"}, SW2_DB, d2);
    endtask

    initial begin
        RST_N = 1'b0;
        SW1   = 1'b0;
        SW2   = 1'b0;
        @(posedge CLK);
        #1;
        cmp_en = 1'b1;

        // reset held with both switches pressed
        for (int i = 0; i < 4; i++) begin
            lit("reset", 1'b1, 1'b1);
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
            check("reset_press1", PRESS1, 1'b0);
            check("reset_press2", PRESS2, 1'b0);
`endif
            step(1'b0, 1'b0, 1);
        end
        SW1   = 1'b1;
        SW2   = 1'b1;
        RST_N = 1'b1;
        step(1'b1, 1'b1, 8);
        lit("idle", 1'b1, 1'b1);

        // clean press and release on SW1
        step(1'b0, 1'b1, 5);
        lit("press_early", 1'b1, 1'b1);
        step(1'b0, 1'b1, 1);
        lit("press_accept", 1'b0, 1'b1);
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
        check("press_pulse", PRESS1, 1'b1);
`endif
        step(1'b0, 1'b1, 1);
        lit("press_hold", 1'b0, 1'b1);
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
        check("press_pulse_end", PRESS1, 1'b0);
`endif
        step(1'b1, 1'b1, 5);
        lit("release_early", 1'b0, 1'b1);
        step(1'b1, 1'b1, 1);
        lit("release_accept", 1'b1, 1'b1);
        step(1'b1, 1'b1, 4);

        // bounce 0,1,0,1 then 0 held
        step(1'b0, 1'b1, 1);
        step(1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 1);
        step(1'b1, 1'b1, 1);
        lit("bounce_mid", 1'b1, 1'b1);
        step(1'b0, 1'b1, 5);
        lit("bounce_early", 1'b1, 1'b1);
        step(1'b0, 1'b1, 1);
        lit("bounce_accept", 1'b0, 1'b1);
        step(1'b1, 1'b1, 8);
        lit("bounce_release", 1'b1, 1'b1);

        // SW2 glitch on the sample that would have completed the count
        step(1'b1, 1'b0, CNT_MAX - 1);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 5);
        lit("glitch_early", 1'b1, 1'b1);
        step(1'b1, 1'b0, 1);
        lit("glitch_accept", 1'b1, 1'b0);
        step(1'b1, 1'b1, 8);
        lit("glitch_release", 1'b1, 1'b1);

        // simultaneous press and release
        step(1'b0, 1'b0, 5);
        lit("sim_early", 1'b1, 1'b1);
        step(1'b0, 1'b0, 1);
        lit("sim_accept", 1'b0, 1'b0);
        step(1'b1, 1'b1, 5);
        lit("sim_rel_early", 1'b0, 1'b0);
        step(1'b1, 1'b1, 1);
        lit("sim_rel_accept", 1'b1, 1'b1);
`ifdef SW_DEBOUNCE_PRESS_PULSE_EN
        check("sim_rel_press1", PRESS1, 1'b0);
        check("sim_rel_press2", PRESS2, 1'b0);
`endif
        step(1'b1, 1'b1, 4);

        // reset pulse three cycles into a press
        step(1'b0, 1'b1, 3);
        RST_N = 1'b0;
        step(1'b0, 1'b1, 1);
        lit("midrst_in_reset", 1'b1, 1'b1);
        RST_N = 1'b1;
        step(1'b0, 1'b1, 5);
        lit("midrst_early", 1'b1, 1'b1);
        step(1'b0, 1'b1, 1);
        lit("midrst_accept", 1'b0, 1'b1);
        step(1'b1, 1'b1, 8);
        lit("final", 1'b1, 1'b1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
